// File: rtl/mbus_tx_line_encoder.sv
// M-bus TX line stage: turns start/data/end commands into a Manchester-coded line with driver enable.
// Latency: first half-bit on tx_line one cycle after an accepted command rise; each half-bit lasts HALF_BIT_CLKS.
// Backpressure: tx_rdy low while a symbol sequence is on the line; rises arriving then are dropped with err_pulse.
// Optional frame statistics (frame_cnt, last_len) are built when TX_FRAME_STATS_EN is defined.
module mbus_tx_line_encoder #(
   parameter int HALF_BIT_CLKS = 4,
   parameter int PRE_BITS      = 8,
   parameter int WIDTH         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             wr_en,
   input  logic             ctrl_en,
   output logic             tx_rdy,
   output logic             tx_line,
   output logic             tx_oe,
`ifdef TX_FRAME_STATS_EN
   output logic [15:0]      frame_cnt,
   output logic [10:0]      last_len,
`endif
   output logic             err_pulse
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] PRE    = 3'd1;
   localparam logic [2:0] SYNC_J = 3'd2;
   localparam logic [2:0] SYNC_K = 3'd3;
   localparam logic [2:0] DATA   = 3'd4;
   localparam logic [2:0] END_T1 = 3'd5;
   localparam logic [2:0] END_T2 = 3'd6;

   localparam logic [7:0] HALF_LAST = 8'(HALF_BIT_CLKS - 1);

   logic [2:0]       state;
   logic [7:0]       timer;
   logic             half;
   logic [3:0]       bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic             wr_q;
   logic             ctrl_q;
   logic             in_frame;
   logic             err_q;

   logic rise_wr;
   logic rise_ctrl;
   logic half_end;
   logic frame_start;

   assign rise_wr     = wr_en & ~wr_q;
   assign rise_ctrl   = ctrl_en & ~ctrl_q;
   assign half_end    = (timer == HALF_LAST);
   assign frame_start = (state == IDLE) & rise_ctrl & (data_in == WIDTH'(0)) & ~in_frame;

   assign tx_rdy    = (state == IDLE);
   assign tx_oe     = in_frame;
   assign err_pulse = err_q;

   // Remember previous enable levels so that only rising edges act as commands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q   <= 1'b0;
         ctrl_q <= 1'b0;
      end else begin
         wr_q   <= wr_en;
         ctrl_q <= ctrl_en;
      end
   end

   // Command acceptance, half-bit timing and symbol sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= 8'd0;
         half     <= 1'b0;
         bit_cnt  <= 4'd0;
         shreg    <= '0;
         in_frame <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (state == IDLE) begin
            timer <= 8'd0;
            half  <= 1'b0;
            if (rise_ctrl) begin
               // ctrl wins a same-cycle collision; the data command is lost
               if (rise_wr)
                  err_q <= 1'b1;
               if (frame_start) begin
                  state    <= PRE;
                  in_frame <= 1'b1;
                  bit_cnt  <= 4'(PRE_BITS);
               end else if ((data_in == WIDTH'(1)) && in_frame) begin
                  state <= END_T1;
               end else begin
                  err_q <= 1'b1;
               end
            end else if (rise_wr) begin
               if (in_frame) begin
                  state   <= DATA;
                  shreg   <= data_in;
                  bit_cnt <= 4'(WIDTH);
               end else begin
                  err_q <= 1'b1;
               end
            end
         end else begin
            // busy: new commands are dropped, the symbol on the line is untouched
            if (rise_wr | rise_ctrl)
               err_q <= 1'b1;
            if (!half_end) begin
               timer <= timer + 8'd1;
            end else begin
               timer <= 8'd0;
               half  <= ~half;
               if (half) begin
                  case (state)
                     PRE: begin
                        if (bit_cnt == 4'd1)
                           state <= SYNC_J;
                        bit_cnt <= bit_cnt - 4'd1;
                     end
                     SYNC_J: state <= SYNC_K;
                     SYNC_K: state <= IDLE;
                     DATA: begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        if (bit_cnt == 4'd1)
                           state <= IDLE;
                        bit_cnt <= bit_cnt - 4'd1;
                     end
                     END_T1: state <= END_T2;
                     END_T2: begin
                        state    <= IDLE;
                        in_frame <= 1'b0;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         end
      end
   end

   // Line level from the current symbol and half: '1' is high-then-low, J high, K low.
   always_comb begin
      tx_line = 1'b0;
      case (state)
         PRE:                    tx_line = ~half;
         SYNC_J, END_T1, END_T2: tx_line = 1'b1;
         SYNC_K:                 tx_line = 1'b0;
         DATA:                   tx_line = shreg[WIDTH-1] ^ half;
         default:                tx_line = 1'b0;
      endcase
   end

`ifdef TX_FRAME_STATS_EN
   logic [10:0] byte_cnt;
   logic        byte_acc;
   logic        frame_done;

   assign byte_acc   = (state == IDLE) & rise_wr & ~rise_ctrl & in_frame;
   assign frame_done = (state == END_T2) & half_end & half;

   // Count bytes of the open frame and publish totals when the end delimiter completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt  <= 11'd0;
         frame_cnt <= 16'd0;
         last_len  <= 11'd0;
      end else begin
         if (frame_start)
            byte_cnt <= 11'd0;
         else if (byte_acc && (byte_cnt != 11'h7FF))
            byte_cnt <= byte_cnt + 11'd1;
         if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
            last_len  <= byte_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mbus_tx_line_encoder.sv
// Bench for mbus_tx_line_encoder: directed commands, queue-based line model, literal pins.
// Latency: n/a (testbench).
// Backpressure: commands are issued only when the sequence under test intends it.
module tb_mbus_tx_line_encoder;

   localparam int H = 4;
   localparam int P = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'd0;
   logic       wr_en = 1'b0;
   logic       ctrl_en = 1'b0;
   logic       tx_rdy, tx_line, tx_oe, err_pulse;
`ifdef TX_FRAME_STATS_EN
   logic [15:0] frame_cnt;
   logic [10:0] last_len;
`endif

   mbus_tx_line_encoder #(.HALF_BIT_CLKS(H), .PRE_BITS(P), .WIDTH(8)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .ctrl_en(ctrl_en),
      .tx_rdy(tx_rdy), .tx_line(tx_line), .tx_oe(tx_oe),
`ifdef TX_FRAME_STATS_EN
      .frame_cnt(frame_cnt), .last_len(last_len),
`endif
      .err_pulse(err_pulse));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit running = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural model: per-cycle line/oe waveform queue ----------------
   typedef struct packed { logic line; logic oe; } smp_t;
   smp_t wave[$];

   logic        m_wr_q = 1'b0, m_ctrl_q = 1'b0, m_in_frame = 1'b0;
   logic        e_rdy = 1'b1, e_line = 1'b0, e_oe = 1'b0, e_err = 1'b0;
   int          m_bytes = 0;
   logic        pend_close = 1'b0;
   int          pend_len = 0;
   logic [15:0] e_fcnt = 16'd0;
   logic [10:0] e_llen = 11'd0;

   logic m_rw, m_rc;
   assign m_rw = wr_en & ~m_wr_q;
   assign m_rc = ctrl_en & ~m_ctrl_q;

   task automatic push_half(input logic l);
      smp_t s;
      s.line = l;
      s.oe   = 1'b1;
      for (int i = 0; i < H; i++) wave.push_back(s);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wave.delete();
         m_wr_q <= 1'b0; m_ctrl_q <= 1'b0; m_in_frame <= 1'b0;
         e_rdy <= 1'b1; e_line <= 1'b0; e_oe <= 1'b0; e_err <= 1'b0;
         m_bytes <= 0; pend_close <= 1'b0; pend_len <= 0;
         e_fcnt <= 16'd0; e_llen <= 11'd0;
      end else begin
         m_wr_q   <= wr_en;
         m_ctrl_q <= ctrl_en;
         e_err    <= 1'b0;
         if (wave.size() == 0 && pend_close) begin
            pend_close <= 1'b0;
            e_fcnt     <= e_fcnt + 16'd1;
            e_llen     <= 11'(pend_len);
         end
         if (m_rw || m_rc) begin
            if (!e_rdy) begin
               e_err <= 1'b1;
            end else if (m_rc) begin
               if (m_rw) e_err <= 1'b1;
               if (data_in == 8'h00 && !m_in_frame) begin
                  for (int i = 0; i < P; i++) begin push_half(1'b1); push_half(1'b0); end
                  push_half(1'b1); push_half(1'b1);
                  push_half(1'b0); push_half(1'b0);
                  m_in_frame <= 1'b1;
                  m_bytes    <= 0;
               end else if (data_in == 8'h01 && m_in_frame) begin
                  for (int i = 0; i < 4; i++) push_half(1'b1);
                  m_in_frame <= 1'b0;
                  pend_close <= 1'b1;
                  pend_len   <= m_bytes;
               end else begin
                  e_err <= 1'b1;
               end
            end else begin
               if (m_in_frame) begin
                  for (int i = 7; i >= 0; i--) begin
                     push_half(data_in[i]);
                     push_half(~data_in[i]);
                  end
                  m_bytes <= (m_bytes < 2047) ? m_bytes + 1 : 2047;
               end else begin
                  e_err <= 1'b1;
               end
            end
         end
         if (wave.size() > 0) begin
            e_line <= wave[0].line;
            e_oe   <= wave[0].oe;
            e_rdy  <= 1'b0;
            wave.delete(0);
         end else begin
            e_line <= 1'b0;
            e_oe   <= m_in_frame;
            e_rdy  <= 1'b1;
         end
      end
   end

   // Compare DUT against the model on every cycle, away from the active edge.
   always @(negedge clk) begin
      if (running) begin
         chk("model_rdy", 32'(tx_rdy), 32'(e_rdy));
         chk("model_line", 32'(tx_line), 32'(e_line));
         chk("model_oe", 32'(tx_oe), 32'(e_oe));
         chk("model_err", 32'(err_pulse), 32'(e_err));
`ifdef TX_FRAME_STATS_EN
         chk("model_frame_cnt", 32'(frame_cnt), 32'(e_fcnt));
         chk("model_last_len", 32'(last_len), 32'(e_llen));
`endif
      end
   end

   // Issue one command at the current negedge (cycle N) and follow it until tx_rdy.
   // pat collects tx_line at the first cycle of each half-bit; lat is cycles from N to tx_rdy.
   task automatic do_cmd(input logic is_ctrl, input logic [7:0] d, input int hold,
                         input logic both, input int ovr_at, input int err_at, input int span,
                         output logic [31:0] pat, output int lat);
      int c;
      data_in = d;
      if (is_ctrl) ctrl_en = 1'b1; else wr_en = 1'b1;
      if (both) wr_en = 1'b1;
      pat = 32'd0;
      lat = -1;
      c = 0;
      while (lat < 0 && c < span + 2 * H + 2) begin
         @(negedge clk);
         c++;
         if (c == hold) begin ctrl_en = 1'b0; wr_en = 1'b0; end
         if (ovr_at != 0 && c == ovr_at) wr_en = 1'b1;
         if (ovr_at != 0 && c == ovr_at + 1) wr_en = 1'b0;
         if (c == err_at) chk("err_pulse_at", 32'(err_pulse), 32'd1);
         if (((c - 1) % H) == 0 && (c - 1) < span) pat = {pat[30:0], tx_line};
         if (tx_rdy) lat = c;
      end
      ctrl_en = 1'b0;
      wr_en   = 1'b0;
   endtask

   logic [31:0] pat;
   int          lat;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_rdy", 32'(tx_rdy), 32'd1);
      chk("reset_line", 32'(tx_line), 32'd0);
      chk("reset_oe", 32'(tx_oe), 32'd0);
      chk("reset_err", 32'(err_pulse), 32'd0);
      reset   = 1'b0;
      running = 1'b1;
      @(negedge clk);

      // protocol errors with no open frame
      do_cmd(1'b0, 8'h33, 1, 1'b0, 0, 1, 0, pat, lat);
      chk("wr_noframe_lat", 32'(lat), 32'd1);
      chk("wr_noframe_oe", 32'(tx_oe), 32'd0);
      @(negedge clk);
      do_cmd(1'b1, 8'h07, 1, 1'b0, 0, 1, 0, pat, lat);
      chk("ctrl07_lat", 32'(lat), 32'd1);
      chk("ctrl07_oe", 32'(tx_oe), 32'd0);
      @(negedge clk);
      do_cmd(1'b1, 8'h01, 1, 1'b0, 0, 1, 0, pat, lat);
      chk("end_noframe_oe", 32'(tx_oe), 32'd0);
      @(negedge clk);

      // start frame: 8 x '1', J, K
      do_cmd(1'b1, 8'h00, 1, 1'b0, 0, 0, (2 * P + 4) * H, pat, lat);
      chk("start_pattern", pat, 32'h000AAAAC);
      chk("start_lat", 32'(lat), 32'd81);
      @(negedge clk);
      chk("gap_line", 32'(tx_line), 32'd0);
      chk("gap_oe", 32'(tx_oe), 32'd1);

      // start while a frame is open is rejected
      do_cmd(1'b1, 8'h00, 1, 1'b0, 0, 1, 0, pat, lat);
      chk("start_inframe_lat", 32'(lat), 32'd1);
      @(negedge clk);

      // data 0xA5, enable held two cycles
      do_cmd(1'b0, 8'hA5, 2, 1'b0, 0, 0, 16 * H, pat, lat);
      chk("a5_pattern", pat, 32'h00009966);
      chk("a5_lat", 32'(lat), 32'd65);
      // back-to-back 0x3C with an overrun rise at N+10
      do_cmd(1'b0, 8'h3C, 1, 1'b0, 10, 11, 16 * H, pat, lat);
      chk("3c_pattern", pat, 32'h00005AA5);
      chk("3c_lat", 32'(lat), 32'd65);
      @(negedge clk);
      do_cmd(1'b0, 8'hFF, 1, 1'b0, 0, 0, 16 * H, pat, lat);
      chk("ff_pattern", pat, 32'h0000AAAA);
      @(negedge clk);

      // end delimiter
      do_cmd(1'b1, 8'h01, 1, 1'b0, 0, 0, 4 * H, pat, lat);
      chk("end_pattern", pat, 32'h0000000F);
      chk("end_lat", 32'(lat), 32'd17);
      chk("end_oe", 32'(tx_oe), 32'd0);
      chk("end_line", 32'(tx_line), 32'd0);
`ifdef TX_FRAME_STATS_EN
      chk("stats_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("stats_last_len", 32'(last_len), 32'd3);
`endif
      @(negedge clk);

      // empty frame closed by a same-cycle ctrl+wr collision (ctrl wins)
      do_cmd(1'b1, 8'h00, 1, 1'b0, 0, 0, (2 * P + 4) * H, pat, lat);
      @(negedge clk);
      do_cmd(1'b1, 8'h01, 1, 1'b1, 0, 1, 4 * H, pat, lat);
      chk("collide_lat", 32'(lat), 32'd17);
      chk("collide_oe", 32'(tx_oe), 32'd0);
`ifdef TX_FRAME_STATS_EN
      chk("stats2_frame_cnt", 32'(frame_cnt), 32'd2);
      chk("stats2_last_len", 32'(last_len), 32'd0);
`endif
      @(negedge clk);

      // reset in the middle of a byte
      do_cmd(1'b1, 8'h00, 1, 1'b0, 0, 0, (2 * P + 4) * H, pat, lat);
      data_in = 8'h81;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (19) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midreset_oe", 32'(tx_oe), 32'd0);
      chk("midreset_line", 32'(tx_line), 32'd0);
      chk("midreset_rdy", 32'(tx_rdy), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
`ifdef TX_FRAME_STATS_EN
      chk("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
      do_cmd(1'b1, 8'h00, 1, 1'b0, 0, 0, (2 * P + 4) * H, pat, lat);
      chk("restart_pattern", pat, 32'h000AAAAC);
      chk("restart_lat", 32'(lat), 32'd81);
      repeat (3) @(negedge clk);

      running = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
